// File: rtl/multdiv_iter_if.sv
// Request/result bundle between the EX stage and the iterative HI/LO multiply/divide unit.
// The master drives op requests; the slave returns status and the HI/LO registers.
interface multdiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  flush, start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/multdiv_iter.sv
// HI/LO multiply/divide unit: fixed-latency multiply/accumulate, radix-2 restoring divide,
// direct MTHI/MTLO writes, with flush abort and a done pulse on writeback.
module multdiv_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic           clk,
  input logic           reset,
  multdiv_iter_if.slave bus
);

  localparam int unsigned CntMax = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMadd  = 4'd5;
  localparam logic [3:0] OpMaddu = 4'd6;
  localparam logic [3:0] OpMsub  = 4'd7;
  localparam logic [3:0] OpMsubu = 4'd8;
  localparam logic [3:0] OpMthi  = 4'd9;
  localparam logic [3:0] OpMtlo  = 4'd10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
  typedef enum logic [1:0] {AccSet, AccAdd, AccSub} acc_e;

  state_e             state_q, state_d;
  acc_e               acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               accept;
  logic               is_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, acc_cur;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh, diff;

  always_comb begin
    accept    = bus.start && !bus.flush && (state_q == StIdle) &&
                (bus.op inside {[OpMult:OpMtlo]});
    is_signed = bus.op inside {OpMult, OpDiv, OpMadd, OpMsub};
    a_ext     = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    b_ext     = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    product   = a_ext * b_ext;
    a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // One restoring step: shift the next dividend bit into the partial remainder.
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    acc_cur   = {hi_q, lo_q};
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (bus.op)
            OpMthi: hi_d = bus.a;
            OpMtlo: lo_d = bus.a;
            OpDiv, OpDivu: begin
              if (bus.b == '0) begin
                // Divide by zero skips iteration; FIX writes these unchanged.
                quo_d     = '1;
                rem_d     = bus.a;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                dz_d      = 1'b1;
                state_d   = StFix;
              end else begin
                quo_d     = a_mag;
                dvs_d     = b_mag;
                rem_d     = '0;
                neg_quo_d = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_d = is_signed && bus.a[WIDTH-1];
                dz_d      = 1'b0;
                cnt_d     = CntW'(WIDTH - 1);
                state_d   = StDiv;
              end
            end
            default: begin
              prod_d  = product;
              acc_d   = (bus.op inside {OpMadd, OpMaddu}) ? AccAdd :
                        (bus.op inside {OpMsub, OpMsubu}) ? AccSub : AccSet;
              cnt_d   = CntW'(MUL_CYCLES - 1);
              state_d = StMul;
            end
          endcase
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          unique case (acc_q)
            AccAdd:  {hi_d, lo_d} = acc_cur + prod_q;
            AccSub:  {hi_d, lo_d} = acc_cur - prod_q;
            default: {hi_d, lo_d} = prod_q;
          endcase
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDiv: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        lo_d       = neg_quo_q ? -quo_q : quo_q;
        hi_d       = neg_rem_q ? -rem_q : rem_q;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush beats everything, including a writeback due on this edge.
    if (bus.flush && (state_q != StIdle)) begin
      state_d    = StIdle;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      acc_q      <= AccSet;
      cnt_q      <= '0;
      prod_q     <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
